// File: rtl/nco_uart_ctrl.sv
// UART command front-end for the NCO: receives 8N1 frames, decodes two-byte commands
// and drives the NCO mode bits and enable-aligned FCW load strobes.
module nco_uart_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned TIMEOUT_BITS = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       rxIn,
    output logic [7:0] dataOut,
    output logic [7:0] ctrlOut,
    output logic       frameError,
    output logic       busy
);

    localparam int unsigned HalfBit = CLKS_PER_BIT / 2;
    localparam int unsigned CntW    = $clog2(CLKS_PER_BIT);
    localparam int unsigned ToW     = $clog2(TIMEOUT_BITS + 1);

    localparam logic [1:0] CmdMode  = 2'd1;
    localparam logic [1:0] CmdFcwLo = 2'd2;
    localparam logic [1:0] CmdFcwHi = 2'd3;

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rxState_e;
    typedef enum logic [1:0] {PsCmd, PsData, PsIssue} psState_e;

    // Synchronizer and edge detect
    logic rxMeta, rxSync, rxPrev;

    // RX FSM
    rxState_e       rxStateQ, rxStateD;
    logic [CntW-1:0] bitCntQ, bitCntD;
    logic [2:0]     bitIdxQ, bitIdxD;
    logic [7:0]     shiftQ, shiftD;
    logic [7:0]     rxByteQ, rxByteD;
    logic           rxDoneQ, rxDoneD;
    logic           stopBitQ, stopBitD;
    logic           byteValidQ;

    // Parser
    psState_e       psStateQ, psStateD;
    logic [1:0]     cmdQ, cmdD;
    logic [7:0]     argQ, argD;
    logic [7:0]     bufQ, bufD;
    logic           bufFullQ, bufFullD;
    logic [1:0]     modeQ, modeD;
    logic [7:0]     dataQ, dataD;
    logic           strobeLoQ, strobeLoD;
    logic           strobeHiQ, strobeHiD;
    logic           frameErrorQ, frameErrorD;
    logic [CntW-1:0] toCycQ, toCycD;
    logic [ToW-1:0] toBitsQ, toBitsD;

    logic           haveByte;
    logic [7:0]     inByte;
    logic           rxActive;
    logic           badStop;

    always_comb begin
        rxStateD = rxStateQ;
        bitCntD  = bitCntQ;
        bitIdxD  = bitIdxQ;
        shiftD   = shiftQ;
        rxByteD  = rxByteQ;
        rxDoneD  = 1'b0;
        stopBitD = stopBitQ;
        unique case (rxStateQ)
            RxIdle: begin
                if (rxPrev && !rxSync) begin
                    rxStateD = RxStart;
                    bitCntD  = CntW'(HalfBit - 1);
                end
            end
            RxStart: begin
                if (bitCntQ == '0) begin
                    if (!rxSync) begin
                        rxStateD = RxData;
                        bitCntD  = CntW'(CLKS_PER_BIT - 1);
                        bitIdxD  = '0;
                    end else begin
                        rxStateD = RxIdle;
                    end
                end else begin
                    bitCntD = bitCntQ - 1'b1;
                end
            end
            RxData: begin
                if (bitCntQ == '0) begin
                    shiftD  = {rxSync, shiftQ[7:1]};
                    bitCntD = CntW'(CLKS_PER_BIT - 1);
                    if (bitIdxQ == 3'd7) begin
                        rxStateD = RxStop;
                    end else begin
                        bitIdxD = bitIdxQ + 1'b1;
                    end
                end else begin
                    bitCntD = bitCntQ - 1'b1;
                end
            end
            RxStop: begin
                if (bitCntQ == '0) begin
                    rxDoneD  = 1'b1;
                    stopBitD = rxSync;
                    rxByteD  = shiftQ;
                    rxStateD = RxIdle;
                end else begin
                    bitCntD = bitCntQ - 1'b1;
                end
            end
            default: rxStateD = RxIdle;
        endcase
    end

    // A buffered byte always takes precedence over a freshly received one.
    assign haveByte = bufFullQ | byteValidQ;
    assign inByte   = bufFullQ ? bufQ : rxByteQ;
    assign rxActive = (rxStateQ != RxIdle) | rxDoneQ;
    assign badStop  = rxDoneQ & ~stopBitQ;

    always_comb begin
        psStateD    = psStateQ;
        cmdD        = cmdQ;
        argD        = argQ;
        bufD        = bufQ;
        bufFullD    = bufFullQ;
        modeD       = modeQ;
        dataD       = dataQ;
        strobeLoD   = 1'b0;
        strobeHiD   = 1'b0;
        frameErrorD = 1'b0;
        toCycD      = toCycQ;
        toBitsD     = toBitsQ;

        // Consuming the buffer in CMD/DATA; a simultaneous new byte refills it.
        if (psStateQ != PsIssue && bufFullQ) begin
            if (byteValidQ) begin
                bufD = rxByteQ;
            end else begin
                bufFullD = 1'b0;
            end
        end

        unique case (psStateQ)
            PsCmd: begin
                if (haveByte) begin
                    if (inByte[7:2] == 6'd0 && inByte[1:0] != 2'd0) begin
                        cmdD     = inByte[1:0];
                        psStateD = PsData;
                        toCycD   = '0;
                        toBitsD  = '0;
                    end else begin
                        frameErrorD = 1'b1;
                    end
                end
            end
            PsData: begin
                if (haveByte) begin
                    argD     = inByte;
                    psStateD = PsIssue;
                end else if (rxActive) begin
                    // Only idle-line time counts; a byte in flight is never timed out.
                    toCycD  = '0;
                    toBitsD = '0;
                end else if (toCycQ == CntW'(CLKS_PER_BIT - 1)) begin
                    toCycD = '0;
                    if (toBitsQ == ToW'(TIMEOUT_BITS - 1)) begin
                        frameErrorD = 1'b1;
                        psStateD    = PsCmd;
                    end else begin
                        toBitsD = toBitsQ + 1'b1;
                    end
                end else begin
                    toCycD = toCycQ + 1'b1;
                end
            end
            PsIssue: begin
                if (byteValidQ) begin
                    if (bufFullQ) begin
                        frameErrorD = 1'b1;
                    end
                    bufD     = rxByteQ;
                    bufFullD = 1'b1;
                end
                if (cmdQ == CmdMode) begin
                    modeD    = argQ[1:0];
                    psStateD = PsCmd;
                end else if (enable) begin
                    dataD     = argQ;
                    strobeLoD = (cmdQ == CmdFcwLo);
                    strobeHiD = (cmdQ == CmdFcwHi);
                    psStateD  = PsCmd;
                end
            end
            default: psStateD = PsCmd;
        endcase

        if (badStop) begin
            frameErrorD = 1'b1;
            psStateD    = PsCmd;
            bufFullD    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxMeta      <= 1'b1;
            rxSync      <= 1'b1;
            rxPrev      <= 1'b1;
            rxStateQ    <= RxIdle;
            bitCntQ     <= '0;
            bitIdxQ     <= '0;
            shiftQ      <= '0;
            rxByteQ     <= '0;
            rxDoneQ     <= 1'b0;
            stopBitQ    <= 1'b0;
            byteValidQ  <= 1'b0;
            psStateQ    <= PsCmd;
            cmdQ        <= '0;
            argQ        <= '0;
            bufQ        <= '0;
            bufFullQ    <= 1'b0;
            modeQ       <= '0;
            dataQ       <= '0;
            strobeLoQ   <= 1'b0;
            strobeHiQ   <= 1'b0;
            frameErrorQ <= 1'b0;
            toCycQ      <= '0;
            toBitsQ     <= '0;
        end else begin
            rxMeta      <= rxIn;
            rxSync      <= rxMeta;
            rxPrev      <= rxSync;
            rxStateQ    <= rxStateD;
            bitCntQ     <= bitCntD;
            bitIdxQ     <= bitIdxD;
            shiftQ      <= shiftD;
            rxByteQ     <= rxByteD;
            rxDoneQ     <= rxDoneD;
            stopBitQ    <= stopBitD;
            byteValidQ  <= rxDoneQ & stopBitQ;
            psStateQ    <= psStateD;
            cmdQ        <= cmdD;
            argQ        <= argD;
            bufQ        <= bufD;
            bufFullQ    <= bufFullD;
            modeQ       <= modeD;
            dataQ       <= dataD;
            strobeLoQ   <= strobeLoD;
            strobeHiQ   <= strobeHiD;
            frameErrorQ <= frameErrorD;
            toCycQ      <= toCycD;
            toBitsQ     <= toBitsD;
        end
    end

    assign dataOut    = dataQ;
    assign ctrlOut    = {4'b0000, strobeHiQ, strobeLoQ, modeQ};
    assign frameError = frameErrorQ;
    // The stop-sample-to-parser pipeline counts as part of the frame.
    assign busy       = (rxStateQ != RxIdle) | rxDoneQ | byteValidQ | (psStateQ != PsCmd) |
                        bufFullQ;

endmodule

// File: tb/tb_nco_uart_ctrl.sv
// Self-checking bench for nco_uart_ctrl: vector table, hand-written corner sequences and a
// randomized command stream checked against a byte-level command model.
module tb_nco_uart_ctrl;

    localparam int CPB         = 4;
    localparam int TOB         = 8;
    localparam int FrameCycles = 10 * CPB;
    // Start-bit drive to output change: 2-flop sync + edge detect, half-bit plus 9 bit-times
    // to the stop sample, then byte-valid, argument register and output register.
    localparam int OutLatency  = 3 + CPB / 2 + 9 * CPB + 3;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       enable = 1'b1;
    logic       rxIn   = 1'b1;
    logic [7:0] dataOut;
    logic [7:0] ctrlOut;
    logic       frameError;
    logic       busy;

    nco_uart_ctrl #(
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_BITS(TOB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .rxIn      (rxIn),
        .dataOut   (dataOut),
        .ctrlOut   (ctrlOut),
        .frameError(frameError),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: running totals, sampled on the falling edge.
    int         loTotal = 0, hiTotal = 0, errTotal = 0, bothCnt = 0, upperCnt = 0;
    int         lastStrobeCyc = -1;
    logic [7:0] lastStrobeData = 8'h00;
    always @(negedge clk) begin
        if (ctrlOut[2]) begin
            loTotal        <= loTotal + 1;
            lastStrobeCyc  <= cyc;
            lastStrobeData <= dataOut;
        end
        if (ctrlOut[3]) begin
            hiTotal        <= hiTotal + 1;
            lastStrobeCyc  <= cyc;
            lastStrobeData <= dataOut;
        end
        if (ctrlOut[2] && ctrlOut[3]) bothCnt <= bothCnt + 1;
        if (ctrlOut[7:4] != 4'h0) upperCnt <= upperCnt + 1;
        if (frameError) errTotal <= errTotal + 1;
    end

    int nCompared = 0;
    int nMismatched = 0;

    task automatic check(input string name, input int act, input int exp);
        nCompared++;
        if (act != exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drives the first nBits bits of an 8N1 frame; must be called at a falling edge.
    task automatic sendFrame(input logic [7:0] b, input logic stopBit, input int nBits);
        logic [9:0] bits;
        bits = {stopBit, b, 1'b0};
        for (int i = 0; i < nBits; i++) begin
            rxIn = bits[i];
            repeat (CPB) @(negedge clk);
        end
        if (nBits == 10) rxIn = 1'b1;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Command byte immediately followed by its argument byte.
    task automatic doPair(input logic [7:0] cmd, input logic [7:0] arg, output int start);
        @(negedge clk);
        start = cyc;
        sendFrame(cmd, 1'b1, 10);
        sendFrame(arg, 1'b1, 10);
        settle(10);
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] arg;
        bit         hasArg;
        int         expMode;
        int         expData;
        int         expLo;
        int         expHi;
        int         expErr;
    } vec_t;

    vec_t vecs[6];

    int         start, bLo, bHi, bErr, m;
    int         mMode, mData, eLo, eHi;
    logic [7:0] rc, ra;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'h02, 8'h34, 1'b1, 0, 8'h34, 1, 0, 0};
        vecs[1] = '{8'h03, 8'h12, 1'b1, 0, 8'h12, 0, 1, 0};
        vecs[2] = '{8'h01, 8'h03, 1'b1, 3, 8'h12, 0, 0, 0};
        vecs[3] = '{8'h01, 8'hFE, 1'b1, 2, 8'h12, 0, 0, 0};
        vecs[4] = '{8'h07, 8'h00, 1'b0, 2, 8'h12, 0, 0, 1};
        vecs[5] = '{8'h01, 8'h01, 1'b1, 1, 8'h12, 0, 0, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        settle(20);
        check("reset dataOut", int'(dataOut), 0);
        check("reset ctrlOut", int'(ctrlOut), 0);
        check("reset busy", int'(busy), 0);
        check("reset no frameError", errTotal, 0);

        // Vector table
        for (int i = 0; i < 6; i++) begin
            bLo = loTotal; bHi = hiTotal; bErr = errTotal;
            if (vecs[i].hasArg) begin
                doPair(vecs[i].cmd, vecs[i].arg, start);
            end else begin
                @(negedge clk);
                start = cyc;
                sendFrame(vecs[i].cmd, 1'b1, 10);
                settle(12);
            end
            check($sformatf("vec%0d mode", i), int'(ctrlOut[1:0]), vecs[i].expMode);
            check($sformatf("vec%0d dataOut", i), int'(dataOut), vecs[i].expData);
            check($sformatf("vec%0d loStrobes", i), loTotal - bLo, vecs[i].expLo);
            check($sformatf("vec%0d hiStrobes", i), hiTotal - bHi, vecs[i].expHi);
            check($sformatf("vec%0d errors", i), errTotal - bErr, vecs[i].expErr);
            check($sformatf("vec%0d busy", i), int'(busy), 0);
            if (vecs[i].expLo + vecs[i].expHi > 0) begin
                check($sformatf("vec%0d strobe cycle", i), lastStrobeCyc,
                      start + FrameCycles + OutLatency);
                check($sformatf("vec%0d strobe data", i), int'(lastStrobeData),
                      vecs[i].expData);
            end
        end

        // Strobe held off while enable is low
        bHi = hiTotal;
        enable = 1'b0;
        doPair(8'h03, 8'h56, start);
        settle(10);
        check("disabled no strobe", hiTotal - bHi, 0);
        check("disabled dataOut held", int'(dataOut), 8'h12);
        check("disabled busy", int'(busy), 1);
        @(negedge clk);
        enable = 1'b1;
        m = cyc;
        settle(5);
        check("enabled one strobe", hiTotal - bHi, 1);
        check("enabled strobe cycle", lastStrobeCyc, m + 1);
        check("enabled strobe data", int'(lastStrobeData), 8'h56);
        check("enabled busy", int'(busy), 0);

        // Bad stop bit drops the byte
        bErr = errTotal; bLo = loTotal;
        @(negedge clk);
        sendFrame(8'h02, 1'b0, 10);
        settle(10);
        check("bad stop error", errTotal - bErr, 1);
        doPair(8'h01, 8'h03, start);
        check("after bad stop mode", int'(ctrlOut[1:0]), 3);
        check("after bad stop no strobe", loTotal - bLo, 0);
        check("after bad stop errors", errTotal - bErr, 1);

        // Timeout between command and argument
        bErr = errTotal;
        @(negedge clk);
        sendFrame(8'h02, 1'b1, 10);
        settle((TOB + 4) * CPB);
        check("timeout error", errTotal - bErr, 1);
        check("timeout busy", int'(busy), 0);
        doPair(8'h01, 8'h01, start);
        check("after timeout mode", int'(ctrlOut[1:0]), 1);
        check("after timeout errors", errTotal - bErr, 1);

        // One-cycle glitch on the line
        bErr = errTotal; bLo = loTotal; bHi = hiTotal;
        @(negedge clk);
        rxIn = 1'b0;
        @(negedge clk);
        rxIn = 1'b1;
        settle(30);
        check("glitch no error", errTotal - bErr, 0);
        check("glitch no strobe", (loTotal - bLo) + (hiTotal - bHi), 0);
        check("glitch busy", int'(busy), 0);
        check("glitch mode", int'(ctrlOut[1:0]), 1);

        // Reset during data bit 4 of the argument byte
        bErr = errTotal; bLo = loTotal;
        @(negedge clk);
        sendFrame(8'h02, 1'b1, 10);
        sendFrame(8'hAA, 1'b1, 5);
        ra = 8'hAA;
        rxIn = ra[4];
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        rxIn = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        settle(100);
        check("reset abort no strobe", loTotal - bLo, 0);
        check("reset abort no error", errTotal - bErr, 0);
        check("reset abort dataOut", int'(dataOut), 0);
        check("reset abort ctrlOut", int'(ctrlOut), 0);
        check("reset abort busy", int'(busy), 0);
        doPair(8'h02, 8'h5A, start);
        check("post reset strobe", loTotal - bLo, 1);
        check("post reset strobe cycle", lastStrobeCyc, start + FrameCycles + OutLatency);
        check("post reset dataOut", int'(dataOut), 8'h5A);

        // Randomized command stream against a byte-level model
        mMode = 0;
        mData = 8'h5A;
        for (int i = 0; i < 12; i++) begin
            rc = 8'($urandom_range(1, 3));
            ra = 8'($urandom_range(0, 255));
            eLo = 0;
            eHi = 0;
            if (rc == 8'h01) begin
                mMode = int'(ra[1:0]);
            end else begin
                mData = int'(ra);
                if (rc == 8'h02) eLo = 1;
                else eHi = 1;
            end
            bLo = loTotal; bHi = hiTotal; bErr = errTotal;
            doPair(rc, ra, start);
            check($sformatf("rand%0d mode", i), int'(ctrlOut[1:0]), mMode);
            check($sformatf("rand%0d dataOut", i), int'(dataOut), mData);
            check($sformatf("rand%0d loStrobes", i), loTotal - bLo, eLo);
            check($sformatf("rand%0d hiStrobes", i), hiTotal - bHi, eHi);
            check($sformatf("rand%0d errors", i), errTotal - bErr, 0);
            if (eLo + eHi > 0) begin
                check($sformatf("rand%0d strobe cycle", i), lastStrobeCyc,
                      start + FrameCycles + OutLatency);
                check($sformatf("rand%0d strobe data", i), int'(lastStrobeData), mData);
            end
        end

        check("strobes never together", bothCnt, 0);
        check("ctrlOut upper nibble zero", upperCnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
